// File: rtl/lutram_pkg.sv
// Shared state type and INIT word extraction for the dual-port LUT RAM.
package lutram_pkg;

  localparam int unsigned MAX_WIDTH     = 64;
  localparam int unsigned MAX_ADDR_W    = 8;
  localparam int unsigned MAX_INIT_BITS = MAX_WIDTH * (2 ** MAX_ADDR_W);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } lutram_st_t;

  // Word k of a zero-extended INIT image; caller truncates to its own width.
  function automatic logic [MAX_WIDTH-1:0] init_word(
    input logic [MAX_INIT_BITS-1:0] init,
    input int unsigned              width,
    input int unsigned              k
  );
    logic [MAX_INIT_BITS-1:0] shifted;
    shifted = init >> (k * width);
    return shifted[MAX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/lutram_clr_seq.sv
// Clear sequencer: restores every word from INIT after reset or on request,
// otherwise passes user writes through to the array.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | user writes pass through; CLR starts a restore
//   ST_CLEAR | one INIT word per cycle at clr_addr; user writes dropped
module lutram_clr_seq
  import lutram_pkg::*;
#(
  parameter int unsigned                      WIDTH  = 8,
  parameter int unsigned                      ADDR_W = 5,
  parameter logic [WIDTH*(2**ADDR_W)-1:0]     INIT   = '0
) (
  input  logic              clk_sys,
  input  logic              rst_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  data,
  input  logic              clr,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_data
);

  localparam int unsigned              DEPTH     = 2 ** ADDR_W;
  localparam logic [MAX_INIT_BITS-1:0] INIT_EXT  = MAX_INIT_BITS'(INIT);
  localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(DEPTH - 1);

  lutram_st_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    mem_we       = 1'b0;
    mem_addr     = addr;
    mem_data     = data;
    case (state)
      ST_IDLE: begin
        // A write on the same edge as a CLR accept is dropped.
        if (clr) begin
          state_nxt    = ST_CLEAR;
          clr_addr_nxt = '0;
        end else begin
          mem_we = we;
        end
      end
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_addr     = clr_addr;
        mem_data     = WIDTH'(init_word(INIT_EXT, WIDTH, 32'(clr_addr)));
        clr_addr_nxt = clr_addr + ADDR_W'(1);
        if (clr_addr == LAST_ADDR) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CLEAR);

endmodule

// File: rtl/lutram_dp_init.sv
// Dual-port distributed RAM (one R/W port, one read port) with INIT restore
// on reset release or CLR, and optionally registered read-first DPO.
module lutram_dp_init
  import lutram_pkg::*;
#(
  parameter int unsigned                  WIDTH   = 8,
  parameter int unsigned                  ADDR_W  = 5,
  parameter logic [WIDTH*(2**ADDR_W)-1:0] INIT    = '0,
  parameter bit                           DPO_REG = 1'b0
) (
  input  logic              WCLK,
  input  logic              RSTN,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] DPRA,
  input  logic              CLR,
  output logic [WIDTH-1:0]  SPO,
  output logic [WIDTH-1:0]  DPO,
  output logic              BUSY
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Array contents are never reset; the sequencer restores them instead.
  logic [DEPTH-1:0][WIDTH-1:0] mem = INIT;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_data;

  lutram_clr_seq #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .INIT   (INIT)
  ) u_clr_seq (
    .clk_sys  (WCLK),
    .rst_b    (RSTN),
    .we       (WE),
    .addr     (A),
    .data     (D),
    .clr      (CLR),
    .busy     (BUSY),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  // The sequencer sits in ST_CLEAR during reset; hold writes until release.
  always_ff @(posedge WCLK) begin
    if (mem_we && RSTN) mem[mem_addr] <= mem_data;
  end

  assign SPO = mem[A];

  if (DPO_REG) begin : g_dpo_reg
    logic [WIDTH-1:0] dpo_q;
    always_ff @(posedge WCLK or negedge RSTN) begin
      if (!RSTN) dpo_q <= '0;
      else       dpo_q <= mem[DPRA];
    end
    assign DPO = dpo_q;
  end else begin : g_dpo_async
    assign DPO = mem[DPRA];
  end

endmodule

// File: tb/tb_lutram_dp_init.sv
// Bench for lutram_dp_init: 8-bit async/registered pair, 32x1 and 256x64 sweeps.
module tb_lutram_dp_init;

  localparam int NI = 4;  // 0: 8b async DPO, 1: 8b reg DPO, 2: 32x1, 3: 256x64
  localparam logic [31:0] INIT1 = 32'hA5C3_0F96;

  function automatic logic [255:0] mk_init8();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r[k*8 +: 8] = 8'(k + 64);
    return r;
  endfunction

  function automatic logic [63:0] w64(input int k);
    return {32'(k) * 32'h9E37_79B1, ~32'(k)};
  endfunction

  function automatic logic [16383:0] mk_init64();
    logic [16383:0] r;
    r = '0;
    for (int k = 0; k < 256; k++) r[k*64 +: 64] = w64(k);
    return r;
  endfunction

  localparam logic [255:0]   INIT8  = mk_init8();
  localparam logic [16383:0] INIT64 = mk_init64();

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic       we0 = 1'b0, clr0 = 1'b0;
  logic [4:0] a0 = '0, dpra0 = '0;
  logic [7:0] d0 = '0;
  logic       we1 = 1'b0, clr1 = 1'b0;
  logic [4:0] a1 = '0, dpra1 = '0;
  logic [0:0] d1 = '0;
  logic       we2 = 1'b0, clr2 = 1'b0;
  logic [7:0] a2 = '0, dpra2 = '0;
  logic [63:0] d2 = '0;

  logic [7:0]  spo0a, dpo0a, spo0b, dpo0b;
  logic        busy0a, busy0b, busy1, busy2;
  logic [0:0]  spo1, dpo1;
  logic [63:0] spo2, dpo2;

  lutram_dp_init #(.WIDTH(8), .ADDR_W(5), .INIT(INIT8), .DPO_REG(1'b0)) u8a (
    .WCLK(clk), .RSTN(rstn), .WE(we0), .A(a0), .D(d0), .DPRA(dpra0), .CLR(clr0),
    .SPO(spo0a), .DPO(dpo0a), .BUSY(busy0a));
  lutram_dp_init #(.WIDTH(8), .ADDR_W(5), .INIT(INIT8), .DPO_REG(1'b1)) u8b (
    .WCLK(clk), .RSTN(rstn), .WE(we0), .A(a0), .D(d0), .DPRA(dpra0), .CLR(clr0),
    .SPO(spo0b), .DPO(dpo0b), .BUSY(busy0b));
  lutram_dp_init #(.WIDTH(1), .ADDR_W(5), .INIT(INIT1), .DPO_REG(1'b0)) u1 (
    .WCLK(clk), .RSTN(rstn), .WE(we1), .A(a1), .D(d1), .DPRA(dpra1), .CLR(clr1),
    .SPO(spo1), .DPO(dpo1), .BUSY(busy1));
  lutram_dp_init #(.WIDTH(64), .ADDR_W(8), .INIT(INIT64), .DPO_REG(1'b1)) u64 (
    .WCLK(clk), .RSTN(rstn), .WE(we2), .A(a2), .D(d2), .DPRA(dpra2), .CLR(clr2),
    .SPO(spo2), .DPO(dpo2), .BUSY(busy2));

  int n_err = 0;
  int n_chk = 0;

  // Reference model: word array, words still to restore, registered DPO value.
  int          m_depth [NI] = '{32, 32, 32, 256};
  bit          m_reg   [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [63:0] m_mem   [NI][256];
  int          m_left  [NI];
  logic [63:0] m_dpo   [NI];

  function automatic logic [63:0] init_w(input int i, input int k);
    logic [31:0] b;
    logic [63:0] w;
    b = INIT1;
    case (i)
      0, 1:    w = 64'(k + 64);
      2:       w = {63'b0, b[k]};
      default: w = w64(k);
    endcase
    return w;
  endfunction

  task automatic get_in(input int i, output bit we, output int a, output logic [63:0] d,
                        output int dpra, output bit clr);
    case (i)
      0, 1:    begin we = we0; a = int'(a0); d = 64'(d0); dpra = int'(dpra0); clr = clr0; end
      2:       begin we = we1; a = int'(a1); d = 64'(d1); dpra = int'(dpra1); clr = clr1; end
      default: begin we = we2; a = int'(a2); d = d2;      dpra = int'(dpra2); clr = clr2; end
    endcase
  endtask

  task automatic get_out(input int i, output logic [63:0] spo, output logic [63:0] dpo,
                         output bit busy);
    case (i)
      0:       begin spo = 64'(spo0a); dpo = 64'(dpo0a); busy = busy0a; end
      1:       begin spo = 64'(spo0b); dpo = 64'(dpo0b); busy = busy0b; end
      2:       begin spo = 64'(spo1);  dpo = 64'(dpo1);  busy = busy1;  end
      default: begin spo = spo2;       dpo = dpo2;       busy = busy2;  end
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_left[i] = m_depth[i];
      m_dpo[i]  = '0;
    end
  endtask

  task automatic model_step();
    bit we, clr;
    int a, dpra, k;
    logic [63:0] d, old;
    if (!rstn) return;
    for (int i = 0; i < NI; i++) begin
      get_in(i, we, a, d, dpra, clr);
      old = m_mem[i][dpra];
      if (m_left[i] > 0) begin
        k = m_depth[i] - m_left[i];
        m_mem[i][k] = init_w(i, k);
        m_left[i]--;
      end else if (clr) begin
        m_left[i] = m_depth[i];
      end else if (we) begin
        m_mem[i][a] = d;
      end
      m_dpo[i] = old;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input int i);
    bit we, clr, busy;
    int a, dpra;
    logic [63:0] d, spo, dpo;
    get_in(i, we, a, d, dpra, clr);
    get_out(i, spo, dpo, busy);
    chk($sformatf("mdl u%0d spo a=%0d", i, a), spo, m_mem[i][a]);
    chk($sformatf("mdl u%0d dpo dpra=%0d", i, dpra), dpo,
        m_reg[i] ? m_dpo[i] : m_mem[i][dpra]);
    chk($sformatf("mdl u%0d busy", i), 64'(busy), 64'(m_left[i] > 0));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check_model(i);
  endtask

  typedef struct {
    bit         we;
    logic [4:0] a;
    logic [7:0] d;
    logic [4:0] dpra;
    logic [7:0] spo;
    logic [7:0] dpo_a;
    logic [7:0] dpo_r;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    tbl[0] = '{1'b1, 5'd7,  8'h5C, 5'd7,  8'h5C, 8'h5C, 8'h47};
    tbl[1] = '{1'b0, 5'd7,  8'h00, 5'd7,  8'h5C, 8'h5C, 8'h5C};
    tbl[2] = '{1'b1, 5'd9,  8'hF0, 5'd9,  8'hF0, 8'hF0, 8'h49};
    tbl[3] = '{1'b0, 5'd9,  8'h00, 5'd9,  8'hF0, 8'hF0, 8'hF0};
    tbl[4] = '{1'b0, 5'd3,  8'h00, 5'd9,  8'h43, 8'hF0, 8'hF0};
    tbl[5] = '{1'b1, 5'd31, 8'h11, 5'd0,  8'h11, 8'h40, 8'h40};
    tbl[6] = '{1'b0, 5'd0,  8'h00, 5'd31, 8'h40, 8'h11, 8'h11};

    for (int i = 0; i < NI; i++)
      for (int k = 0; k < m_depth[i]; k++) m_mem[i][k] = init_w(i, k);
    model_reset();

    // Reset clear, with a write attempted throughout BUSY.
    #1 rstn = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst busy", 64'(busy0a), 64'd1);
    chk("rst dpo_reg", 64'(dpo0b), 64'd0);
    rstn = 1'b1;
    we0 = 1'b1; a0 = 5'd3; d0 = 8'hAA;
    n = 0;
    do begin tick(); n++; end while (busy0a && n < 200);
    chk("rst busy cycles", 64'(n), 64'd32);
    we0 = 1'b0;
    #1 chk("rst mem3 kept", 64'(spo0a), 64'h43);

    // Writes and reads in IDLE.
    for (int v = 0; v < 7; v++) begin
      we0 = tbl[v].we; a0 = tbl[v].a; d0 = tbl[v].d; dpra0 = tbl[v].dpra;
      tick();
      chk($sformatf("tbl%0d spo", v), 64'(spo0a), 64'(tbl[v].spo));
      chk($sformatf("tbl%0d dpo async", v), 64'(dpo0a), 64'(tbl[v].dpo_a));
      chk($sformatf("tbl%0d dpo reg", v), 64'(dpo0b), 64'(tbl[v].dpo_r));
      chk($sformatf("tbl%0d busy", v), 64'(busy0a), 64'd0);
    end
    we0 = 1'b0;

    // CLR collides with a write; a second CLR inside the window is ignored.
    we0 = 1'b1; clr0 = 1'b1; a0 = 5'd2; d0 = 8'h00; dpra0 = 5'd2;
    tick();
    we0 = 1'b0; clr0 = 1'b0;
    #1;
    chk("clr write dropped", 64'(spo0a), 64'h42);
    chk("clr busy rise", 64'(busy0a), 64'd1);
    n = 0;
    do begin
      clr0 = (n == 10);
      tick();
      n++;
    end while (busy0a && n < 200);
    clr0 = 1'b0;
    chk("clr busy cycles", 64'(n), 64'd32);
    for (int k = 0; k < 32; k++) begin
      a0 = 5'(k); dpra0 = 5'(k);
      #1;
      chk($sformatf("clr word %0d", k), 64'(spo0a), 64'(k + 64));
    end

    // Reset asserted mid-clear at clr_addr 12.
    we0 = 1'b1; a0 = 5'd20; d0 = 8'h99;
    tick();
    we0 = 1'b0; dpra0 = 5'd5;
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    repeat (12) tick();
    rstn = 1'b0;
    model_reset();
    #1;
    chk("midrst busy", 64'(busy0a), 64'd1);
    chk("midrst dpo_reg", 64'(dpo0b), 64'd0);
    repeat (3) tick();
    chk("midrst busy held", 64'(busy0a), 64'd1);
    chk("midrst dpo_reg held", 64'(dpo0b), 64'd0);
    rstn = 1'b1;
    n = 0;
    do begin tick(); n++; end while (busy0a && n < 200);
    chk("midrst busy cycles", 64'(n), 64'd32);
    #1 chk("midrst word20", 64'(spo0a), 64'h54);

    // Random traffic on every instance against the model.
    for (int c = 0; c < 10000; c++) begin
      if (c % 2500 == 1250) begin
        rstn = 1'b0;
        model_reset();
      end else if (c % 2500 == 1252) begin
        rstn = 1'b1;
      end
      we0 = 1'($urandom); a0 = 5'($urandom); d0 = 8'($urandom);
      dpra0 = 5'($urandom); clr0 = ($urandom_range(0, 199) == 0);
      we1 = 1'($urandom); a1 = 5'($urandom); d1 = 1'($urandom);
      dpra1 = 5'($urandom); clr1 = ($urandom_range(0, 199) == 0);
      we2 = 1'($urandom); a2 = 8'($urandom); d2 = {$urandom, $urandom};
      dpra2 = 8'($urandom); clr2 = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lutram_dp_init.md
# lutram_dp_init

Parametrised dual-port distributed (LUT) RAM: one read/write port, one read-only port, configurable word width and depth. Contents are restored from `INIT` by a built-in clear sequencer, both after reset release and on request. `DPO` can optionally be registered. It replaces fixed 32x1 dual-port RAM cells wherever a wider or deeper simulation-friendly LUT RAM is needed, for example register files and small FIFOs.

## Interface
- `WIDTH`, 8: data word width in bits, 1..64.
- `ADDR_W`, 5: address width; depth is `DEPTH = 2**ADDR_W`, with `ADDR_W` in 1..8.
- `INIT`, all zeros, `WIDTH*DEPTH` bits: power-up and clear contents. Word `k` is `INIT[k*WIDTH +: WIDTH]`.
- `DPO_REG`, 0: selects the `DPO` read mode.
  - 0: `DPO` is an asynchronous read.
  - 1: `DPO` is registered, with one cycle of latency.

- `WCLK`, in, 1: the single clock. All state updates on its rising edge.
- `RSTN`, in, 1: reset, asynchronous, active-low.
- `WE`, in, 1: write enable for port A.
- `A`, in, `ADDR_W`: read/write address.
- `D`, in, `WIDTH`: write data.
- `DPRA`, in, `ADDR_W`: read-only port address.
- `CLR`, in, 1: single-cycle request to reload every word from `INIT`.
- `SPO`, out, `WIDTH`: asynchronous read of `mem[A]`.
- `DPO`, out, `WIDTH`: read of `mem[DPRA]`, either asynchronous or registered per `DPO_REG`.
- `BUSY`, out, 1: the clear sequence is running; user writes are ignored while high.

## Operation
- The array `mem` has `DEPTH` x `WIDTH` bits. It is initialised to `INIT` at time zero and is never asynchronously reset.
- **Sequencer states:**
  - `ST_IDLE`: user writes are allowed.
  - `ST_CLEAR`: an `ADDR_W`-bit counter `clr_addr` writes `INIT` word `clr_addr` into `mem[clr_addr]`, one word per cycle.
- **Reset:** `RSTN` low forces `ST_CLEAR`, `clr_addr = 0`, `BUSY = 1`, and registered `DPO = 0`. The sequence runs from the first rising edge after `RSTN` goes high.
- **IDLE to CLEAR:** taken when `CLR = 1` in `ST_IDLE`. `clr_addr` is loaded with 0, and `BUSY` rises the next cycle.
- **CLEAR to IDLE:** taken on the edge that writes `clr_addr = DEPTH-1`. `clr_addr` wraps to 0 and `BUSY` falls after that edge.
- **User writes:** in `ST_IDLE` with `WE = 1`, `mem[A] <= D`.
  - A write is dropped when it coincides with a `CLR` accept (clear wins).
  - All writes are dropped while `BUSY = 1`.
- `CLR` asserted while `BUSY = 1` is ignored; the running sequence is not restarted.
- **Reads during `BUSY`:** reads remain live and return the partially restored contents.
- **`RSTN` asserted mid-clear:** the counter aborts to 0. The words already written keep their `INIT` values, and the full sequence reruns after release.

## Timing
- `SPO` updates combinationally on `A` changes, and after the rising edge that writes the addressed word.
- **`DPO_REG = 0`:** `DPO` behaves the same way as `SPO`, but for `DPRA`.
- **`DPO_REG = 1`:** `DPO(n+1) = mem(n)[DPRA(n)]`, i.e. read-first. On an edge where `DPRA == A` and a write occurs, `DPO` shows the old word and the new word appears one cycle later.
- **Clear duration:** after `CLR` is sampled high in `ST_IDLE`, `BUSY` is high for exactly `DEPTH` cycles. After reset release it is high for `DEPTH` cycles counted from the first edge.
- **First accepted write:** on the first edge where `BUSY` is sampled low.
- **Reset values:** `BUSY = 1`, registered `DPO = 0`. `SPO` and asynchronous `DPO` reflect array contents.

## Structure
- **Package `lutram_pkg`:**
  - state typedef `lutram_st_t` with `ST_IDLE` and `ST_CLEAR`;
  - a helper function extracting word `k` from `INIT`.
- **Sub-module `lutram_clr_seq`:** holds the FSM, the `clr_addr` counter and the `BUSY` logic. It outputs the muxed write enable, address and data into the array.
- The top level holds the array, the read muxes and the optional `DPO` register (generate on `DPO_REG`).

## Test plan
- **Reset clear:** `WIDTH=8`, `ADDR_W=5`, `INIT` word `k = k+8'h40`. Pulse `RSTN` low, release, then drive `WE=1`, `A=3`, `D=8'hAA` during `BUSY`.
  - Required: `BUSY` high for 32 cycles.
  - Required: `mem[3]` stays `8'h43`.
- **Write and asynchronous read:** in IDLE, write `A=7`, `D=8'h5C`.
  - Required: `SPO` reads `8'h5C` after the edge.
  - Required: with `DPO_REG=0` and `DPRA=7`, `DPO` reads `8'h5C` after the same edge.
- **Registered read-first:** `DPO_REG=1`, `DPRA=A=9`, write `8'hF0` over the initial `8'h49`.
  - Required: `DPO` shows `8'h49` on the write edge.
  - Required: `DPO` shows `8'hF0` one cycle later.
- **CLR collision:** assert `CLR` and `WE` (`A=2`, `D=8'h00`) on the same edge.
  - Required: the write is dropped and `BUSY` is high for 32 cycles.
  - Required: a second `CLR` inside the window does not extend `BUSY`.
  - Required: afterwards all words equal `INIT`.
- **Reset mid-clear:** assert `RSTN` low at `clr_addr=12`.
  - Required: `BUSY` stays 1 and registered `DPO` is 0 while reset is held.
  - Required: after release, `BUSY` lasts a full 32 cycles.
- **Parameter sweep:** `WIDTH=1`, `ADDR_W=5` (32x1 equivalent), and `WIDTH=64`, `ADDR_W=8`, with random `WE`/`A`/`D`/`DPRA`/`CLR` traffic for 10k cycles.
  - Required: the outputs match a scoreboard model cycle-for-cycle.
